// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: shares one memory port between instruction fetch and data access, D first with an IF anti-starvation streak limit.
// Define ARB_PERF_COUNT_EN to build the per-requester stall-cycle counters.
module pipeline_mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_BUSY,
  input  logic        D_READ,
  input  logic        D_WRITE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic [31:0] D_RDATA,
  output logic        D_BUSY,
  output logic        MM_READ,
  output logic        MM_WRITE,
  output logic [31:0] MM_ADDR,
  output logic [31:0] MM_WDATA,
  input  logic [31:0] MM_RDATA,
  input  logic        MM_ACK,
  output logic [31:0] IF_STALL_CNT,
  output logic [31:0] D_STALL_CNT
);
  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D} state_t;
  state_t r_state;
  logic [3:0] r_streak;
  logic w_d_req, w_d_grant;
  logic [3:0] w_streak_inc;
  assign w_d_req = D_READ | D_WRITE;
  assign w_d_grant = w_d_req & (~IF_REQ | (r_streak < 4'(MAX_D_STREAK)));
  assign w_streak_inc = (r_streak == 4'(MAX_D_STREAK)) ? r_streak : r_streak + 4'd1;
  assign IF_BUSY = IF_REQ & (r_state != DONE_I);
  assign D_BUSY = w_d_req & (r_state != DONE_D);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_streak <= '0;
      IF_RDATA <= '0;
      D_RDATA <= '0;
      MM_READ <= 1'b0;
      MM_WRITE <= 1'b0;
      MM_ADDR <= '0;
      MM_WDATA <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_grant) begin
            r_state <= SERVE_D;
            r_streak <= IF_REQ ? w_streak_inc : 4'd0;
            MM_ADDR <= D_ADDR;
            MM_WDATA <= D_WDATA;
            MM_WRITE <= D_WRITE;
            MM_READ <= ~D_WRITE;
          end else if (IF_REQ) begin
            r_state <= SERVE_I;
            r_streak <= '0;
            MM_ADDR <= IF_ADDR;
            MM_READ <= 1'b1;
            MM_WRITE <= 1'b0;
          end
        end
        SERVE_I: begin
          if (MM_ACK) begin
            r_state <= DONE_I;
            MM_READ <= 1'b0;
            IF_RDATA <= MM_RDATA;
          end
        end
        SERVE_D: begin
          if (MM_ACK) begin
            r_state <= DONE_D;
            MM_READ <= 1'b0;
            MM_WRITE <= 1'b0;
            if (MM_READ) D_RDATA <= MM_RDATA;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef ARB_PERF_COUNT_EN
  logic [31:0] r_if_stall_cnt, r_d_stall_cnt;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_if_stall_cnt <= '0;
      r_d_stall_cnt <= '0;
    end else begin
      r_if_stall_cnt <= r_if_stall_cnt + 32'(IF_BUSY);
      r_d_stall_cnt <= r_d_stall_cnt + 32'(D_BUSY);
    end
  end
  assign IF_STALL_CNT = r_if_stall_cnt;
  assign D_STALL_CNT = r_d_stall_cnt;
`else
  assign IF_STALL_CNT = 32'd0;
  assign D_STALL_CNT = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// tb_pipeline_mem_arbiter: directed vectors for pipeline_mem_arbiter.
module tb_pipeline_mem_arbiter;
  logic        CLK = 1'b0, RESET = 1'b1;
  logic        IF_REQ = 1'b0, D_READ = 1'b0, D_WRITE = 1'b0, MM_ACK = 1'b0;
  logic [31:0] IF_ADDR = '0, D_ADDR = '0, D_WDATA = '0, MM_RDATA = '0;
  logic [31:0] IF_RDATA, D_RDATA, MM_ADDR, MM_WDATA, IF_STALL_CNT, D_STALL_CNT;
  logic        IF_BUSY, D_BUSY, MM_READ, MM_WRITE;
  int n_checks = 0, n_fail = 0;
  pipeline_mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_BUSY(IF_BUSY),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA), .D_BUSY(D_BUSY),
    .MM_READ(MM_READ), .MM_WRITE(MM_WRITE), .MM_ADDR(MM_ADDR), .MM_WDATA(MM_WDATA),
    .MM_RDATA(MM_RDATA), .MM_ACK(MM_ACK),
    .IF_STALL_CNT(IF_STALL_CNT), .D_STALL_CNT(D_STALL_CNT)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic ack_now(input logic [31:0] d);
    MM_ACK = 1'b1;
    MM_RDATA = d;
    @(negedge CLK);
    MM_ACK = 1'b0;
    MM_RDATA = '0;
  endtask
  initial begin
    logic [31:0] exp_addr, exp_if_cnt;
    repeat (2) @(negedge CLK);
    check("rst_mm_read", 32'(MM_READ), 0);
    check("rst_mm_write", 32'(MM_WRITE), 0);
    check("rst_mm_addr", MM_ADDR, 0);
    check("rst_mm_wdata", MM_WDATA, 0);
    check("rst_if_rdata", IF_RDATA, 0);
    check("rst_d_rdata", D_RDATA, 0);
    check("rst_if_cnt", IF_STALL_CNT, 0);
    check("rst_d_cnt", D_STALL_CNT, 0);
    RESET = 1'b0;
    // IF-only read
    IF_REQ = 1'b1;
    IF_ADDR = 32'h40;
    #1 check("if_busy_idle", 32'(IF_BUSY), 1);
    @(negedge CLK);
    check("if_mm_read", 32'(MM_READ), 1);
    check("if_mm_write", 32'(MM_WRITE), 0);
    check("if_mm_addr", MM_ADDR, 32'h40);
    check("if_busy_serve", 32'(IF_BUSY), 1);
    ack_now(32'h0051_3093);
    check("if_busy_done", 32'(IF_BUSY), 0);
    check("if_rdata", IF_RDATA, 32'h0051_3093);
    check("if_read_drop", 32'(MM_READ), 0);
    IF_REQ = 1'b0;
    @(negedge CLK);
    check("if_idle_read", 32'(MM_READ), 0);
    // Simultaneous requests: D first
    IF_REQ = 1'b1;
    IF_ADDR = 32'h44;
    D_READ = 1'b1;
    D_ADDR = 32'h100;
    @(negedge CLK);
    check("sim_d_addr", MM_ADDR, 32'h100);
    check("sim_d_read", 32'(MM_READ), 1);
    ack_now(32'hA5A5_0001);
    check("sim_d_busy_done", 32'(D_BUSY), 0);
    check("sim_if_still_busy", 32'(IF_BUSY), 1);
    check("sim_d_rdata", D_RDATA, 32'hA5A5_0001);
    D_READ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("sim_if_addr", MM_ADDR, 32'h44);
    ack_now(32'h0000_0011);
    check("sim_if_busy_done", 32'(IF_BUSY), 0);
    check("sim_if_rdata", IF_RDATA, 32'h11);
    IF_REQ = 1'b0;
    @(negedge CLK);
    // Starvation guard: four D grants, one IF, then D again
    IF_REQ = 1'b1;
    IF_ADDR = 32'h80;
    D_READ = 1'b1;
    D_ADDR = 32'h300;
    for (int g = 0; g < 6; g++) begin
      exp_addr = (g == 4) ? 32'h80 : 32'h300;
      @(negedge CLK);
      check($sformatf("streak_g%0d_addr", g), MM_ADDR, exp_addr);
      ack_now(32'hC0DE_0000 + 32'(g));
      if (g == 4) check("streak_if_done", 32'(IF_BUSY), 0);
      @(negedge CLK);
    end
    check("streak_if_rdata", IF_RDATA, 32'hC0DE_0004);
    check("streak_d_rdata", D_RDATA, 32'hC0DE_0005);
    IF_REQ = 1'b0;
    D_READ = 1'b0;
    @(negedge CLK);
    // Store with a 5-cycle ACK
    D_WRITE = 1'b1;
    D_ADDR = 32'h200;
    D_WDATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("st_write_c%0d", i), 32'(MM_WRITE), 1);
      check($sformatf("st_read_c%0d", i), 32'(MM_READ), 0);
      check($sformatf("st_addr_c%0d", i), MM_ADDR, 32'h200);
      check($sformatf("st_wdata_c%0d", i), MM_WDATA, 32'hDEAD_BEEF);
      check($sformatf("st_busy_c%0d", i), 32'(D_BUSY), 1);
      if (i == 4) begin
        MM_ACK = 1'b1;
        MM_RDATA = 32'h1234_5678;
      end
    end
    @(negedge CLK);
    MM_ACK = 1'b0;
    check("st_busy_done", 32'(D_BUSY), 0);
    check("st_write_drop", 32'(MM_WRITE), 0);
    check("st_rdata_kept", D_RDATA, 32'hC0DE_0005);
    D_WRITE = 1'b0;
    @(negedge CLK);
    // Read and write together is a write
    D_READ = 1'b1;
    D_WRITE = 1'b1;
    D_ADDR = 32'h204;
    D_WDATA = 32'h55;
    @(negedge CLK);
    check("rw_write", 32'(MM_WRITE), 1);
    check("rw_read", 32'(MM_READ), 0);
    ack_now(32'h99);
    check("rw_rdata_kept", D_RDATA, 32'hC0DE_0005);
    D_READ = 1'b0;
    D_WRITE = 1'b0;
    @(negedge CLK);
    // Reset in SERVE_D, then a stray ACK
    D_READ = 1'b1;
    D_ADDR = 32'h400;
    @(negedge CLK);
    check("rst_pre_read", 32'(MM_READ), 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    D_READ = 1'b0;
    check("rst_mid_read", 32'(MM_READ), 0);
    check("rst_mid_addr", MM_ADDR, 0);
    check("rst_mid_drdata", D_RDATA, 0);
    MM_ACK = 1'b1;
    MM_RDATA = 32'hBAD0_BAD0;
    @(negedge CLK);
    MM_ACK = 1'b0;
    check("stray_drdata", D_RDATA, 0);
    check("stray_irdata", IF_RDATA, 0);
    check("stray_read", 32'(MM_READ), 0);
    // IF access with the ACK in the second SERVE cycle
    IF_REQ = 1'b1;
    IF_ADDR = 32'h48;
    @(negedge CLK);
    check("pf_addr", MM_ADDR, 32'h48);
    @(negedge CLK);
    check("pf_busy_wait", 32'(IF_BUSY), 1);
    ack_now(32'h77);
    check("pf_busy_done", 32'(IF_BUSY), 0);
    check("pf_rdata", IF_RDATA, 32'h77);
    IF_REQ = 1'b0;
    @(negedge CLK);
`ifdef ARB_PERF_COUNT_EN
    exp_if_cnt = 32'd3;
`else
    exp_if_cnt = 32'd0;
`endif
    check("pf_if_cnt", IF_STALL_CNT, exp_if_cnt);
    check("pf_d_cnt", D_STALL_CNT, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
